shared_data_ram_para: RTL and testbench

SHARED_DATA_RAM_PARA -- requirements
Module: shared_data_ram_para

---
 rtl/shared_data_ram_para.sv | 149 ++++++++++++++
 tb/tb_shared_data_ram_para.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_data_ram_para.sv
// Multi-port shared RAM: parallel reads, one round-robin write per cycle, and a zeroing sweep.
// Define SHARED_RAM_FORWARD_EN to return same-cycle write data to reads of the written address.
module shared_data_ram_para #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [NUM_PORTS*DATA_W-1:0] rdata,
    output logic                        busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef SHARED_RAM_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

    state_e                             state_q;
    logic [ADDR_W-1:0]                  clr_addr_q;
    logic [PTR_W-1:0]                   rr_ptr_q;
    logic [PTR_W-1:0]                   rr_ptr_d;
    logic                               busy_q;

    logic [NUM_PORTS-1:0]               rd_gnt;
    logic [NUM_PORTS-1:0]               wr_gnt;
    logic                               wr_any;
    logic [PTR_W-1:0]                   wr_port;
    logic [ADDR_W-1:0]                  wr_addr;
    logic [DATA_W-1:0]                  wr_data;

    logic [DATA_W-1:0]                  mem [DEPTH];
    logic [NUM_PORTS-1:0]               rvalid_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_q;

    // Round-robin write pick: ports at or above rr_ptr first, then wrap to the ports below it.
    always_comb begin
        rd_gnt  = '0;
        wr_gnt  = '0;
        wr_any  = 1'b0;
        wr_port = '0;
        if (state_q == S_IDLE) begin
            rd_gnt = req & ~we;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!wr_any && req[i] && we[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                    wr_any  = 1'b1;
                    wr_port = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!wr_any && req[i] && we[i]) begin
                    wr_any  = 1'b1;
                    wr_port = PTR_W'(i);
                end
            end
            if (wr_any) wr_gnt[wr_port] = 1'b1;
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_gnt[i]) begin
                wr_addr = addr[i*ADDR_W +: ADDR_W];
                wr_data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_d = (wr_port == PTR_W'(NUM_PORTS - 1)) ? '0 : wr_port + 1'b1;

    // NOTE: state registers take only non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == {ADDR_W{1'b1}}) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (wr_any) rr_ptr_q <= rr_ptr_d;
                    if (clear) begin
                        state_q    <= S_CLEAR;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    // NOTE: the array has no reset; the sweep zeroes it, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_any) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rvalid_q[i] <= rd_gnt[i];
                if (rd_gnt[i]) begin
                    if (FWD_EN && wr_any && (addr[i*ADDR_W +: ADDR_W] == wr_addr))
                        rdata_q[i] <= wr_data;
                    else
                        rdata_q[i] <= mem[addr[i*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign gnt    = rd_gnt | wr_gnt;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_shared_data_ram_para.sv
// Self-checking bench for shared_data_ram_para against a cycle-level behavioural model
// (array + round-robin pointer + sweep countdown) with directed scenarios and random traffic.
module tb_shared_data_ram_para;

    localparam int NP = 4;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int DEPTH = 64;

`ifdef SHARED_RAM_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [NP-1:0]    gnt;
    logic [NP-1:0]    rvalid;
    logic [NP*DW-1:0] rdata;
    logic             busy;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_rr;
    int            m_sweep;
    logic [NP-1:0] m_rvalid;
    logic [DW-1:0] m_rdata [NP];
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] obs_gnt;

    shared_data_ram_para #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]           = r;
        we[p]            = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        clear = 1'b0;
    endtask

    // One clock of traffic: predict grants, compare, advance the model, compare registered outputs.
    task automatic cycle(input logic clr);
        logic [NP-1:0] eg;
        logic          eb;
        int            wp;
        int            p;
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        clear = clr;
        #2;
        eg = '0;
        wp = -1;
        if (m_sweep == 0) begin
            for (int i = 0; i < NP; i++)
                if (req[i] && !we[i]) eg[i] = 1'b1;
            for (int j = 0; j < NP; j++) begin
                p = (m_rr + j) % NP;
                if (wp < 0 && req[p] && we[p]) wp = p;
            end
            if (wp >= 0) eg[wp] = 1'b1;
        end
        eb = (m_sweep > 0);
        total++;
        if (gnt !== eg) begin
            bad++;
            $display("FAIL gnt: got %b expected %b at %0t", gnt, eg, $time);
        end
        total++;
        if (busy !== eb) begin
            bad++;
            $display("FAIL busy: got %b expected %b at %0t", busy, eb, $time);
        end
        obs_gnt = gnt;
        exp_gnt = eg;

        wa = (wp >= 0) ? addr[wp*AW +: AW] : '0;
        for (int i = 0; i < NP; i++) begin
            m_rvalid[i] = eg[i] && !we[i];
            if (m_rvalid[i]) begin
                a = addr[i*AW +: AW];
                if (FWD && wp >= 0 && a == wa) m_rdata[i] = wdata[wp*DW +: DW];
                else                           m_rdata[i] = m_mem[a];
            end
        end
        if (wp >= 0) begin
            m_mem[wa] = wdata[wp*DW +: DW];
            m_rr = (wp + 1) % NP;
        end
        if (m_sweep > 0) begin
            m_sweep--;
        end else if (clr) begin
            m_sweep = DEPTH;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        end

        @(posedge clk);
        #1;
        clear = 1'b0;
        total++;
        if (rvalid !== m_rvalid) begin
            bad++;
            $display("FAIL rvalid: got %b expected %b at %0t", rvalid, m_rvalid, $time);
        end
        for (int i = 0; i < NP; i++) begin
            total++;
            if (rdata[i*DW +: DW] !== m_rdata[i]) begin
                bad++;
                $display("FAIL rdata[%0d]: got %h expected %h at %0t",
                         i, rdata[i*DW +: DW], m_rdata[i], $time);
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || gnt !== '0 || rvalid !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_values: busy=%b gnt=%b rvalid=%b rdata=%h expected 1/0/0/0",
                     busy, gnt, rvalid, rdata);
        end
        m_rr     = 0;
        m_sweep  = DEPTH;
        m_rvalid = '0;
        for (int i = 0; i < NP; i++) m_rdata[i] = '0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic count_sweep(input string tag);
        int n;
        n = 0;
        idle_inputs();
        for (int k = 0; k < 70; k++) begin
            if (busy === 1'b1) n++;
            cycle(1'b0);
        end
        total++;
        if (n != DEPTH) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, DEPTH);
        end
    endtask

    task automatic test_reset();
        do_reset();
        count_sweep("reset");
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b0, 6'd5, 8'h00);
        cycle(1'b0);
        total++;
        if (rvalid !== 4'b1111 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_read5: rvalid=%b rdata=%h expected 1111/00000000", rvalid, rdata);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        logic [NP-1:0] seq [4];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1, 6'd10, 8'((i + 1) * 8'h11));
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0);
            total++;
            if (obs_gnt !== seq[c]) begin
                bad++;
                $display("FAIL collision_gnt%0d: got %b expected %b", c, obs_gnt, seq[c]);
            end
            req = req & ~exp_gnt;
        end
        idle_inputs();
        set_port(2, 1'b1, 1'b0, 6'd10, 8'h00);
        cycle(1'b0);
        total++;
        if (rdata[2*DW +: DW] !== 8'h44) begin
            bad++;
            $display("FAIL collision_read: got %h expected 44", rdata[2*DW +: DW]);
        end
        idle_inputs();
    endtask

    task automatic test_fairness();
        logic [NP-1:0] seq [4];
        seq[0] = 4'b0001; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            set_port(0, 1'b1, 1'b1, 6'd20, 8'($urandom));
            set_port(3, 1'b1, 1'b1, 6'd20, 8'($urandom));
            cycle(1'b0);
            total++;
            if (obs_gnt !== seq[c]) begin
                bad++;
                $display("FAIL fairness_gnt%0d: got %b expected %b", c, obs_gnt, seq[c]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_forward();
        logic [DW-1:0] want;
        want = FWD ? 8'hA5 : 8'h00;
        set_port(0, 1'b1, 1'b1, 6'd7, 8'hA5);
        set_port(1, 1'b1, 1'b0, 6'd7, 8'h00);
        cycle(1'b0);
        total++;
        if (rdata[DW +: DW] !== want) begin
            bad++;
            $display("FAIL forward_same_cycle: got %h expected %h", rdata[DW +: DW], want);
        end
        idle_inputs();
        set_port(1, 1'b1, 1'b0, 6'd7, 8'h00);
        cycle(1'b0);
        total++;
        if (rdata[DW +: DW] !== 8'hA5) begin
            bad++;
            $display("FAIL forward_followup: got %h expected a5", rdata[DW +: DW]);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [NP-1:0] pend;
        logic          clr;
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pend[i])
                    set_port(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                             AW'($urandom_range(0, 7)), DW'($urandom));
            end
            clr = (m_sweep == 0) && ($urandom_range(0, 149) == 0);
            cycle(clr);
            pend = req & ~exp_gnt;
        end
        idle_inputs();
        while (m_sweep > 0) cycle(1'b0);
    endtask

    task automatic test_clear_reset();
        set_port(2, 1'b1, 1'b1, 6'd63, 8'h5A);
        cycle(1'b0);
        idle_inputs();
        set_port(3, 1'b1, 1'b0, 6'd63, 8'h00);
        cycle(1'b0);
        total++;
        if (rdata[3*DW +: DW] !== 8'h5A) begin
            bad++;
            $display("FAIL clear_preread: got %h expected 5a", rdata[3*DW +: DW]);
        end
        idle_inputs();
        cycle(1'b1);
        for (int k = 0; k < 20; k++) cycle(1'b0);
        do_reset();
        count_sweep("midsweep_reset");
        set_port(3, 1'b1, 1'b0, 6'd63, 8'h00);
        cycle(1'b0);
        total++;
        if (rvalid[3] !== 1'b1 || rdata[3*DW +: DW] !== 8'h00) begin
            bad++;
            $display("FAIL clear_read63: rvalid=%b data=%h expected 1/00",
                     rvalid[3], rdata[3*DW +: DW]);
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_collision();
        test_fairness();
        test_forward();
        test_random();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
